if_id_buffer: RTL
=================

Name: if_id_buffer

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage.
- Captures each fetched {address, instruction} pair in a small FIFO and presents the oldest one to decode.
- Back-pressures fetch when full; the full indication drives the PC stall.
- Discards all wrong-path entries on a taken-branch flush and presents a NOP whenever empty.

Parameters:
- DEPTH, 2, number of entries; legal values 2 or 4 (power of two).
- NOP, 32'h00000013, instruction word presented when no valid entry (addi x0,x0,0).

Ports:
- i_clock  input  1  rising-edge clock.
- i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_valid  input  1  fetch stage has a valid instruction this cycle.
- i_address  input  32  PC of the fetched instruction.
- i_instruccion  input  32  fetched instruction word.
- o_ready  output  1  buffer accepts a push this cycle; low = stall PC.
- i_flush  input  1  taken branch/jump; discard all contents.
- o_valid  output  1  head entry valid toward decode.
- o_address  output  32  PC of the head entry.
- o_instruccion  output  32  instruction of the head entry, NOP when o_valid=0.
- i_ready  input  1  decode consumes the head entry this cycle.
- o_count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular array of {address, instruction}; rd_ptr, wr_ptr clog2(DEPTH) bits, wrap modulo DEPTH; count held separately. The array itself is not reset.
- push = i_valid & o_ready & ~i_flush; pop = o_valid & i_ready & ~i_flush.
- o_ready = (count < DEPTH), combinational from count only, with no dependency on i_ready (no full-bypass).
- When full, a simultaneous pop does not enable a push in the same cycle; o_ready rises the following cycle.
- count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged; the write goes to wr_ptr and the read advances rd_ptr in the same edge.
- Not empty and not full, push+pop: the head advances to the next older entry; the new entry is appended at the tail.
- Outputs are first-word-fall-through:
  - o_valid = (count != 0).
  - o_address = array[rd_ptr].
  - o_instruccion = array[rd_ptr] when valid, else NOP.
- o_address is 32'h0 when count == 0.
- Latency: an entry pushed at edge N into an empty buffer is visible on o_* after edge N (same cycle after the edge), i.e. 1 cycle fetch-to-decode.
- Flush:
  - Highest priority.
  - At the edge with i_flush=1: count=0, rd_ptr=wr_ptr=0.
  - Any push or pop that cycle is ignored; the incoming instruction is wrong-path and is dropped.
  - The next cycle: o_valid=0, o_instruccion=NOP, o_ready=1.
- Reset (i_reset=0, asynchronous, independent of clock):
  - count=0, pointers=0.
  - o_valid=0, o_ready=1, o_address=0, o_instruccion=NOP, o_count=0.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-stream loses all entries.
- Empty with i_ready=1 and no push: no pointer or count change; underflow impossible.
- Full with i_valid=1 and i_ready=0: no state change; overflow impossible; fetch must hold its inputs.
- i_valid=0: i_address and i_instruccion are ignored.

Test Plan:
- Reset with i_reset=0, then release:
  - o_valid=0, o_instruccion=32'h00000013, o_address=0, o_ready=1, o_count=0.
- Streaming, i_ready=1, push A=0x00 / I=0x00500093, then 0x04 / 0x00A00113:
  - Each appears on o_* one edge after the push, in order.
  - o_count stays ≤1, o_ready stays 1.
- Fill with DEPTH=2 and i_ready=0, pushes 0x08 and 0x0C:
  - o_count=2, o_ready=0.
  - A third push of 0x10 is held and not lost.
  - Raising i_ready pops 0x08, then 0x0C; the next cycle o_ready=1 and 0x10 is accepted.
- Flush with 2 entries held, i_flush=1 while i_valid=1 presents 0x20:
  - Next cycle o_valid=0, o_count=0, o_instruccion=NOP.
  - 0x20 never appears on o_address.
- Half-full push+pop with 1 entry 0x30 and simultaneous push 0x34 and pop:
  - o_count stays 1, o_address=0x34.
- Asynchronous reset mid-operation with 2 entries, i_reset pulsed low between clock edges:
  - Outputs go to reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/if_id_buffer_if.sv
// ---------------------------------------------------------------------------
// if_id_buffer_if
//   Bundles the fetch-side push port and the decode-side pop port of the
//   IF/ID decoupling buffer.
//
//   Handshake (both sides): a transfer happens on a rising edge when the
//   producer's valid and the consumer's ready are both high and i_flush is low.
//   Fetch must hold i_address/i_instruccion stable while o_ready is low.
//
//   Signals
//     i_valid, i_address, i_instruccion  fetch -> buffer  (push side)
//     o_ready                            buffer -> fetch  (low = stall PC)
//     i_flush                            branch unit -> buffer (drop all)
//     o_valid, o_address, o_instruccion  buffer -> decode (head entry)
//     i_ready                            decode -> buffer (consume head)
//     o_count                            buffer occupancy
//
//   Modports
//     slave  : the buffer itself
//     master : the environment driving fetch/decode/flush
// ---------------------------------------------------------------------------
interface if_id_buffer_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_valid;
  logic [31:0]   i_address;
  logic [31:0]   i_instruccion;
  logic          o_ready;
  logic          i_flush;
  logic          o_valid;
  logic [31:0]   o_address;
  logic [31:0]   o_instruccion;
  logic          i_ready;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_valid, i_address, i_instruccion, i_flush, i_ready,
    output o_ready, o_valid, o_address, o_instruccion, o_count
  );

  modport master (
    output i_valid, i_address, i_instruccion, i_flush, i_ready,
    input  o_ready, o_valid, o_address, o_instruccion, o_count
  );
endinterface

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//   Small first-word-fall-through FIFO between instruction fetch and decode.
//   Each accepted {address, instruction} pair is stored in a DEPTH-entry
//   circular array; the oldest entry is presented to decode combinationally.
//   When empty the decode side sees o_valid=0, o_address=0 and a NOP.
//   A flush (taken branch) empties the buffer and drops that cycle's fetch.
//
//   Ports
//     i_clock  rising-edge clock
//     i_reset  asynchronous active-low reset
//     bus      if_id_buffer_if.slave (fetch push port, decode pop port,
//              flush, occupancy)
//
//   Parameters
//     DEPTH  number of entries, 2 or 4
//     NOP    word shown on o_instruccion when empty (addi x0,x0,0)
// ---------------------------------------------------------------------------
module if_id_buffer #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic           i_clock,
  input  logic           i_reset,
  if_id_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   addr_mem  [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic ready;
  logic not_empty;
  logic push;
  logic pop;

  // Ready depends on occupancy only: a pop while full does not free a slot
  // until the following cycle, which keeps o_ready off the decode path.
  assign ready     = (count < CW'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = bus.i_valid & ready     & ~bus.i_flush;
  assign pop       = not_empty   & bus.i_ready & ~bus.i_flush;

  // Pointers and occupancy; flush outranks any push/pop in the same cycle.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; empty-state outputs are masked below.
  always_ff @(posedge i_clock) begin
    if (push) begin
      addr_mem[wr_ptr]  <= bus.i_address;
      instr_mem[wr_ptr] <= bus.i_instruccion;
    end
  end

  // Head presentation.
  always_comb begin
    bus.o_ready       = ready;
    bus.o_valid       = not_empty;
    bus.o_count       = count;
    bus.o_address     = 32'h0;
    bus.o_instruccion = NOP;
    if (not_empty) begin
      bus.o_address     = addr_mem[rd_ptr];
      bus.o_instruccion = instr_mem[rd_ptr];
    end
  end

endmodule
